// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Producer side of the fetch/decode boundary. Owns the PC, issues one
// instruction-memory read at a time and presents INST_F / PC_F / PC4_F with
// valid_F to the IF/ID register. Handles stall from the hazard unit and
// redirects from branch/jump resolution, discarding responses that a
// redirect has made stale.
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   defined   : misalign pulses for one cycle after a redirect whose target
//               has bits[1:0] != 0 (the target is still word-aligned).
//   undefined : misalign is tied low; bits[1:0] are cleared silently.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] INST_F,
    output logic [31:0] PC_F,
    output logic [31:0] PC4_F,
    output logic        valid_F,
    output logic        misalign
);

    // IDLE : one cycle after reset release, nothing in flight
    // REQ  : request is on the bus this cycle
    // WAIT : request issued, waiting for imem_rvalid
    // FULL : output register holds an instruction for decode
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FULL = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic [31:0] pc_q,        pc_d;
    logic        drop_q,      drop_d;
    logic [31:0] out_inst_q,  out_inst_d;
    logic [31:0] out_pc_q,    out_pc_d;
    logic        out_valid_q, out_valid_d;
    logic        misalign_q,  misalign_d;

    // Word-aligned redirect target: the low two bits are always discarded.
    logic [31:0] redirect_tgt;
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};

    // Next-state logic for the fetch FSM, PC, drop flag and output register.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        out_valid_d = out_valid_q;

        if (redirect) begin
            // A redirect beats stall and a same-cycle response.
            pc_d        = redirect_tgt;
            out_valid_d = 1'b0;
            unique case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    // The request leaving this cycle is already stale.
                    state_d = WAIT;
                    drop_d  = 1'b1;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        // The in-flight response is consumed here and
                        // thrown away, so nothing remains to drop.
                        state_d = REQ;
                        drop_d  = 1'b0;
                    end else begin
                        state_d = WAIT;
                        drop_d  = 1'b1;
                    end
                end
                FULL: state_d = REQ;
                default: state_d = IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: state_d = REQ;
                REQ:  state_d = WAIT;
                WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            // Stale response: pc_q already holds the new target.
                            drop_d  = 1'b0;
                            state_d = REQ;
                        end else begin
                            out_inst_d  = imem_rdata;
                            out_pc_d    = pc_q;
                            out_valid_d = 1'b1;
                            pc_d        = pc_q + 32'd4;
                            state_d     = FULL;
                        end
                    end
                end
                FULL: begin
                    // Decode takes the instruction on this edge unless stalled.
                    if (!stall) begin
                        out_valid_d = 1'b0;
                        state_d     = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Misalignment flag: registered so it appears the cycle after the redirect.
`ifdef FETCH_MISALIGN_CHK_EN
    always_comb begin
        misalign_d = redirect && (redirect_pc[1:0] != 2'b00);
    end
`else
    always_comb begin
        misalign_d = 1'b0;
    end
`endif

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            out_inst_q  <= NOP_INST;
            out_pc_q    <= 32'd0;
            out_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
            misalign_q  <= misalign_d;
        end
    end

    // Output decode: request depends on state only, outputs come from flops.
    always_comb begin
        imem_req  = (state_q == REQ);
        imem_addr = pc_q;
        INST_F    = out_valid_q ? out_inst_q : NOP_INST;
        PC_F      = out_pc_q;
        PC4_F     = out_pc_q + 32'd4;
        valid_F   = out_valid_q;
        misalign  = misalign_q;
    end

    // Memory may only respond while a request is outstanding (WAIT); a
    // response in any other state is a protocol violation and is ignored.
    a_rvalid_only_in_wait : assert property (
        @(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> (state_q == WAIT)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. The instruction memory is driven by hand
// from the stimulus sequence so response timing is exact for each scenario.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] INST_F;
    logic [31:0] PC_F;
    logic [31:0] PC4_F;
    logic        valid_F;
    logic        misalign;

    int n_assert;
    int n_fail;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .INST_F      (INST_F),
        .PC_F        (PC_F),
        .PC4_F       (PC4_F),
        .valid_F     (valid_F),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full view of the IF/ID outputs in one call.
    task automatic chk_out(input string tag, input logic v, input logic [31:0] inst,
                           input logic [31:0] pc);
        chk({tag, ".valid"}, {31'd0, valid_F}, {31'd0, v});
        chk({tag, ".inst"}, INST_F, inst);
        chk({tag, ".pc"}, PC_F, pc);
        chk({tag, ".pc4"}, PC4_F, pc + 32'd4);
    endtask

    logic exp_mis;

    initial begin
        n_assert    = 0;
        n_fail      = 0;
`ifdef FETCH_MISALIGN_CHK_EN
        exp_mis     = 1'b1;
`else
        exp_mis     = 1'b0;
`endif
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;

        // Reset state
        tick();
        tick();
        chk("rst.req", {31'd0, imem_req}, 32'd0);
        chk("rst.addr", imem_addr, 32'h0);
        chk_out("rst", 1'b0, 32'h0000_0013, 32'h0);
        chk("rst.misalign", {31'd0, misalign}, 32'd0);

        // Release reset; first request one cycle later at 0x0
        rst_n = 1'b1;
        tick();                                   // IDLE -> REQ
        chk("first.req", {31'd0, imem_req}, 32'd1);
        chk("first.addr", imem_addr, 32'h0);
        tick();                                   // REQ -> WAIT
        chk("first.wait_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0093;
        tick();                                   // WAIT -> FULL
        imem_rvalid = 1'b0;
        chk_out("inst0", 1'b1, 32'h0000_0093, 32'h0);
        tick();                                   // FULL -> REQ
        chk("inst1.req", {31'd0, imem_req}, 32'd1);
        chk("inst1.addr", imem_addr, 32'h4);
        chk("inst1.v0", {31'd0, valid_F}, 32'd0);
        tick();                                   // REQ -> WAIT
        imem_rvalid = 1'b1; imem_rdata = 32'h0010_0113;
        tick();                                   // WAIT -> FULL, 3 cycles after inst0
        imem_rvalid = 1'b0;
        chk_out("inst1", 1'b1, 32'h0010_0113, 32'h4);

        // Stall held 5 cycles in FULL: outputs frozen, no request
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("stall", 1'b1, 32'h0010_0113, 32'h4);
            chk("stall.req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();                                   // FULL -> REQ
        chk("unstall.req", {31'd0, imem_req}, 32'd1);
        chk("unstall.addr", imem_addr, 32'h8);
        chk("unstall.v0", {31'd0, valid_F}, 32'd0);
        tick();                                   // REQ -> WAIT

        // Redirect to 0x100 while WAIT; stale response 2 cycles later
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        chk("rdw.addr", imem_addr, 32'h100);
        chk("rdw.req", {31'd0, imem_req}, 32'd0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();                                   // stale response dropped
        imem_rvalid = 1'b0;
        chk("rdw.drop_v", {31'd0, valid_F}, 32'd0);
        chk("rdw.drop_inst", INST_F, 32'h0000_0013);
        chk("rdw.req", {31'd0, imem_req}, 32'd1);
        chk("rdw.addr2", imem_addr, 32'h100);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0513;
        tick();
        imem_rvalid = 1'b0;
        chk_out("rdw.tgt", 1'b1, 32'h0000_0513, 32'h100);
        tick();                                   // FULL -> REQ at 0x104
        chk("seq.addr", imem_addr, 32'h104);
        tick();                                   // WAIT

        // Redirect to 0x200 in the same cycle as imem_rvalid
        imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        imem_rvalid = 1'b0; redirect = 1'b0;
        chk("rdv.v0", {31'd0, valid_F}, 32'd0);
        chk("rdv.req", {31'd0, imem_req}, 32'd1);
        chk("rdv.addr", imem_addr, 32'h200);
        tick();
        chk("rdv.v0b", {31'd0, valid_F}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0613;
        tick();
        imem_rvalid = 1'b0;
        chk_out("rdv.tgt", 1'b1, 32'h0000_0613, 32'h200);

        // Redirect with stall=1 in FULL
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0240;
        tick();
        redirect = 1'b0;
        chk("rds.v0", {31'd0, valid_F}, 32'd0);
        chk("rds.inst", INST_F, 32'h0000_0013);
        chk("rds.req", {31'd0, imem_req}, 32'd1);
        chk("rds.addr", imem_addr, 32'h240);
        stall = 1'b0;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0713;
        tick();
        imem_rvalid = 1'b0;
        chk_out("rds.tgt", 1'b1, 32'h0000_0713, 32'h240);

        // Misaligned redirect target 0x302
        redirect = 1'b1; redirect_pc = 32'h0000_0302;
        tick();
        redirect = 1'b0;
        chk("mis.flag", {31'd0, misalign}, {31'd0, exp_mis});
        chk("mis.addr", imem_addr, 32'h300);
        chk("mis.req", {31'd0, imem_req}, 32'd1);
        tick();
        chk("mis.flag_off", {31'd0, misalign}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0093;
        tick();
        imem_rvalid = 1'b0;
        chk_out("mis.tgt", 1'b1, 32'h0000_0093, 32'h300);

        // PC4_F wraps at the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("wrap.addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap.mis", {31'd0, misalign}, 32'd0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0193;
        tick();
        imem_rvalid = 1'b0;
        chk("wrap.pc", PC_F, 32'hFFFF_FFFC);
        chk("wrap.pc4", PC4_F, 32'h0000_0000);
        chk("wrap.inst", INST_F, 32'h0000_0193);

        // Reset asserted mid-WAIT; response during reset is ignored
        tick();                                   // FULL -> REQ
        tick();                                   // REQ -> WAIT
        rst_n = 1'b0;
        #1;
        chk("rstw.req", {31'd0, imem_req}, 32'd0);
        chk("rstw.addr", imem_addr, 32'h0);
        chk_out("rstw", 1'b0, 32'h0000_0013, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        tick();
        imem_rvalid = 1'b0;
        rst_n = 1'b1;
        chk("rstw.v0", {31'd0, valid_F}, 32'd0);
        tick();                                   // IDLE -> REQ
        chk("rstw.req2", {31'd0, imem_req}, 32'd1);
        chk("rstw.addr2", imem_addr, 32'h0);
        chk("rstw.v0b", {31'd0, valid_F}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
